// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and the shared coordinate type
// for the VGA raster generator and its axis counters.
package vga_timing_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blank and sync
// flags derived from the next count, plus a combinational end-of-axis wrap.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output logic               blank,
    output logic               sync,
    output logic               wrap
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC - 1;

    coord_t count_q, count_d;
    logic   blank_q, blank_d;
    logic   sync_q, sync_d;

    // Flags look at count_d so they move on the same edge as the count.
    always_comb begin
        wrap    = step && (count_q == coord_t'(TOTAL - 1));
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        blank_d = (count_d >= coord_t'(ACTIVE));
        sync_d  = ((count_d >= coord_t'(SYNC_START)) && (count_d <= coord_t'(SYNC_END)))
                  ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blank = blank_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider feeding horizontal and
// vertical axis counters, with a pixel strobe and a frame-start pulse.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    input  logic               Enable,
    output logic               HS,
    output logic               VS,
    output logic               HBlank,
    output logic               VBlank,
    output logic [COORD_W-1:0] CurrentX,
    output logic [COORD_W-1:0] CurrentY,
    output logic               PixelTick,
    output logic               FrameStart
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (H_TOTAL >= 2048) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL must stay below 2048");
    end
    if (V_TOTAL >= 2048) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL must stay below 2048");
    end
    if (CLK_DIV < 1) begin : g_clk_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             pixel_tick_q, pixel_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap;

    // Divider holds its phase while disabled so resume neither skips nor repeats.
    always_comb begin
        tick          = Enable && (div_q == DIV_LAST);
        div_d         = div_q;
        if (Enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        pixel_tick_d  = tick;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            div_q         <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk   (CLK_100MHz),
        .rst_n (Reset),
        .step  (tick),
        .count (CurrentX),
        .blank (HBlank),
        .sync  (HS),
        .wrap  (h_wrap)
    );

    // Stepping on the horizontal wrap keeps VS and Y changes line-aligned.
    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk   (CLK_100MHz),
        .rst_n (Reset),
        .step  (h_wrap),
        .count (CurrentY),
        .blank (VBlank),
        .sync  (VS),
        .wrap  (v_wrap)
    );

    assign PixelTick  = pixel_tick_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three differently parameterised
// instances compared every cycle against a raster-position model.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        en   [3];
    logic        hs_o [3];
    logic        vs_o [3];
    logic        hb_o [3];
    logic        vb_o [3];
    logic        pt_o [3];
    logic        fs_o [3];
    logic [10:0] x_o  [3];
    logic [10:0] y_o  [3];

    // Geometry per instance: default VGA, tiny CLK_DIV=1, odd sizes with high-active sync.
    int p_div [3] = '{4, 1, 3};
    int p_ha  [3] = '{640, 8, 10};
    int p_hf  [3] = '{16, 2, 3};
    int p_hs  [3] = '{96, 2, 4};
    int p_hb  [3] = '{48, 2, 5};
    int p_va  [3] = '{480, 4, 6};
    int p_vf  [3] = '{10, 1, 2};
    int p_vs  [3] = '{2, 1, 2};
    int p_vb  [3] = '{33, 1, 3};
    int p_pol [3] = '{0, 0, 1};

    longint e_cnt  [3];
    bit     m_tick [3];
    int     n_pass;
    int     n_total;

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b0)
    ) dut0 (
        .CLK_100MHz(clk), .Reset(rst_n), .Enable(en[0]), .HS(hs_o[0]), .VS(vs_o[0]),
        .HBlank(hb_o[0]), .VBlank(vb_o[0]), .CurrentX(x_o[0]), .CurrentY(y_o[0]),
        .PixelTick(pt_o[0]), .FrameStart(fs_o[0])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut1 (
        .CLK_100MHz(clk), .Reset(rst_n), .Enable(en[1]), .HS(hs_o[1]), .VS(vs_o[1]),
        .HBlank(hb_o[1]), .VBlank(vb_o[1]), .CurrentX(x_o[1]), .CurrentY(y_o[1]),
        .PixelTick(pt_o[1]), .FrameStart(fs_o[1])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut2 (
        .CLK_100MHz(clk), .Reset(rst_n), .Enable(en[2]), .HS(hs_o[2]), .VS(vs_o[2]),
        .HBlank(hb_o[2]), .VBlank(vb_o[2]), .CurrentX(x_o[2]), .CurrentY(y_o[2]),
        .PixelTick(pt_o[2]), .FrameStart(fs_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int k, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s[%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    // The raster position is simply the number of pixel ticks seen since reset, modulo a frame.
    task automatic check_output(input int k);
        int     ht, vt, x, y, hs_lo, vs_lo, inact;
        longint p;
        ht    = p_ha[k] + p_hf[k] + p_hs[k] + p_hb[k];
        vt    = p_va[k] + p_vf[k] + p_vs[k] + p_vb[k];
        p     = (e_cnt[k] / p_div[k]) % (ht * vt);
        x     = int'(p % ht);
        y     = int'(p / ht);
        hs_lo = p_ha[k] + p_hf[k];
        vs_lo = p_va[k] + p_vf[k];
        inact = 1 - p_pol[k];
        compare("CurrentX", k, int'(x_o[k]), x);
        compare("CurrentY", k, int'(y_o[k]), y);
        compare("HBlank", k, int'(hb_o[k]), (x >= p_ha[k]) ? 1 : 0);
        compare("VBlank", k, int'(vb_o[k]), (y >= p_va[k]) ? 1 : 0);
        compare("HS", k, int'(hs_o[k]),
                (x >= hs_lo && x < hs_lo + p_hs[k]) ? p_pol[k] : inact);
        compare("VS", k, int'(vs_o[k]),
                (y >= vs_lo && y < vs_lo + p_vs[k]) ? p_pol[k] : inact);
        compare("PixelTick", k, int'(pt_o[k]), m_tick[k] ? 1 : 0);
        compare("FrameStart", k, int'(fs_o[k]), (m_tick[k] && p == 0) ? 1 : 0);
    endtask

    task automatic apply_stimulus(input bit e0, input bit e1, input bit e2);
        en[0] = e0;
        en[1] = e1;
        en[2] = e2;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                e_cnt[k]++;
                m_tick[k] = (e_cnt[k] % p_div[k]) == 0;
            end else begin
                m_tick[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) check_output(k);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_cnt[k]  = 0;
            m_tick[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 3; k++) check_output(k);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_output(k);
        rst_n = 1'b1;
    endtask

    initial begin
        bit b [3];
        int low_run [3];
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k]      = 1'b0;
            low_run[k] = 0;
        end
        #3;
        assert_reset();
        compare("lit_reset_X", 0, int'(x_o[0]), 0);
        compare("lit_reset_HS", 0, int'(hs_o[0]), 1);
        compare("lit_reset_VS", 0, int'(vs_o[0]), 1);
        compare("lit_reset_HS_pol1", 2, int'(hs_o[2]), 0);
        release_reset();

        // Free-running lines with hand-computed landmarks.
        for (int c = 1; c <= 3300; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1);
            case (c)
                3:    begin compare("lit_c3_tick", 0, int'(pt_o[0]), 0);
                            compare("lit_c3_X", 0, int'(x_o[0]), 0); end
                4:    begin compare("lit_c4_tick", 0, int'(pt_o[0]), 1);
                            compare("lit_c4_X", 0, int'(x_o[0]), 1); end
                10:   begin compare("lit_c10_X", 1, int'(x_o[1]), 10);
                            compare("lit_c10_HS", 1, int'(hs_o[1]), 0); end
                12:   compare("lit_c12_HS", 1, int'(hs_o[1]), 1);
                14:   begin compare("lit_c14_X", 1, int'(x_o[1]), 0);
                            compare("lit_c14_Y", 1, int'(y_o[1]), 1); end
                39:   compare("lit_c39_HS_pol1", 2, int'(hs_o[2]), 1);
                56:   compare("lit_c56_VBlank", 1, int'(vb_o[1]), 1);
                70:   compare("lit_c70_VS", 1, int'(vs_o[1]), 0);
                84:   compare("lit_c84_VS", 1, int'(vs_o[1]), 1);
                97:   compare("lit_c97_FrameStart", 1, int'(fs_o[1]), 0);
                98:   begin compare("lit_c98_FrameStart", 1, int'(fs_o[1]), 1);
                            compare("lit_c98_Y", 1, int'(y_o[1]), 0); end
                858:  compare("lit_c858_FrameStart", 2, int'(fs_o[2]), 1);
                2559: compare("lit_c2559_HBlank", 0, int'(hb_o[0]), 0);
                2560: begin compare("lit_c2560_X", 0, int'(x_o[0]), 640);
                            compare("lit_c2560_HBlank", 0, int'(hb_o[0]), 1); end
                2623: compare("lit_c2623_HS", 0, int'(hs_o[0]), 1);
                2624: compare("lit_c2624_HS", 0, int'(hs_o[0]), 0);
                3007: compare("lit_c3007_HS", 0, int'(hs_o[0]), 0);
                3008: compare("lit_c3008_HS", 0, int'(hs_o[0]), 1);
                3199: begin compare("lit_c3199_X", 0, int'(x_o[0]), 799);
                            compare("lit_c3199_Y", 0, int'(y_o[0]), 0); end
                3200: begin compare("lit_c3200_X", 0, int'(x_o[0]), 0);
                            compare("lit_c3200_Y", 0, int'(y_o[0]), 1); end
                default: ;
            endcase
        end

        // Random enable patterns, occasional 37-clock stalls and one mid-run reset.
        for (int i = 0; i < 8000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (low_run[k] > 0) begin
                    low_run[k]--;
                    b[k] = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    low_run[k] = 36;
                    b[k] = 1'b0;
                end else begin
                    b[k] = ($urandom_range(0, 3) != 0);
                end
            end
            apply_stimulus(b[0], b[1], b[2]);
            if (i == 4000) begin
                assert_reset();
                release_reset();
            end
        end

        // Stall at X=123 with the divider mid-period, then resume.
        assert_reset();
        release_reset();
        repeat (494) apply_stimulus(1'b1, 1'b1, 1'b1);
        compare("lit_pre_stall_X", 0, int'(x_o[0]), 123);
        repeat (37) apply_stimulus(1'b0, 1'b1, 1'b1);
        compare("lit_stall_X", 0, int'(x_o[0]), 123);
        compare("lit_stall_tick", 0, int'(pt_o[0]), 0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        compare("lit_resume1_X", 0, int'(x_o[0]), 123);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        compare("lit_resume2_X", 0, int'(x_o[0]), 124);
        compare("lit_resume2_tick", 0, int'(pt_o[0]), 1);

        // Asynchronous reset while instance 1 sits inside its sync window.
        assert_reset();
        release_reset();
        repeat (10) apply_stimulus(1'b1, 1'b1, 1'b1);
        compare("lit_prereset_HS", 1, int'(hs_o[1]), 0);
        assert_reset();
        compare("lit_async_HS", 1, int'(hs_o[1]), 1);
        compare("lit_async_X", 1, int'(x_o[1]), 0);
        compare("lit_async_X0", 0, int'(x_o[0]), 0);
        release_reset();
        repeat (20) apply_stimulus(1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
